// File: rtl/alt_vip_common_frame_arbiter_if.sv
// rtl/alt_vip_common_frame_arbiter_if.sv - VIP Avalon-ST stream bundle used by the frame arbiter
interface alt_vip_common_frame_arbiter_if #(
  parameter int DW = 24
) ();
  logic          valid;
  logic          sop;
  logic          eop;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, output sop, output eop, output data, input  ready);
  modport slave  (input  valid, input  sop, input  eop, input  data, output ready);
endinterface

// File: rtl/alt_vip_common_frame_arbiter.sv
// rtl/alt_vip_common_frame_arbiter.sv - two-source VIP frame arbiter, grant held for a whole frame
// Optional frame counters enabled by VIP_ARB_FRAME_COUNT_EN.
module alt_vip_common_frame_arbiter #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  alt_vip_common_frame_arbiter_if.slave        s0,
  alt_vip_common_frame_arbiter_if.slave        s1,
  alt_vip_common_frame_arbiter_if.master       dout,
  input  logic                                 prio_mode,
  output logic [1:0]                           grant,
  output logic                                 frame_done,
  output logic                                 drop_pulse
`ifdef VIP_ARB_FRAME_COUNT_EN
  ,
  output logic [15:0]                          frame_count0,
  output logic [15:0]                          frame_count1
`endif
);

  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state, state_nxt;
  logic          owner, owner_nxt;
  logic          last_owner;
  logic          in_video;

  logic          own_valid, own_sop, own_eop;
  logic [DW-1:0] own_data;
  logic          cand0, cand1;
  logic          win, arb_go;
  logic          drop0, drop1;
  logic          accept, sop_video, frame_end;

  always_comb begin
    own_valid = owner ? s1.valid : s0.valid;
    own_sop   = owner ? s1.sop   : s0.sop;
    own_eop   = owner ? s1.eop   : s0.eop;
    own_data  = owner ? s1.data  : s0.data;
    cand0     = s0.valid & s0.sop;
    cand1     = s1.valid & s1.sop;
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    win        = 1'b0;
    arb_go     = 1'b0;
    drop0      = 1'b0;
    drop1      = 1'b0;
    accept     = 1'b0;
    frame_end  = 1'b0;
    sop_video  = in_video;
    s0.ready   = 1'b0;
    s1.ready   = 1'b0;
    dout.valid = 1'b0;
    dout.sop   = 1'b0;
    dout.eop   = 1'b0;
    dout.data  = '0;
    case (state)
      IDLE: begin
        // Beats without sop can never start a frame, so flush them while idle.
        drop0    = s0.valid & ~s0.sop & ~rst;
        drop1    = s1.valid & ~s1.sop & ~rst;
        s0.ready = drop0;
        s1.ready = drop1;
        if (cand0 && cand1) begin
          win = prio_mode ? 1'b0 : ~last_owner;
        end else begin
          win = cand1;
        end
        arb_go = cand0 | cand1;
        if (arb_go) begin
          state_nxt = OWN;
          owner_nxt = win;
        end
      end
      OWN: begin
        dout.valid = own_valid;
        dout.sop   = own_sop;
        dout.eop   = own_eop;
        dout.data  = own_data;
        if (owner) begin
          s1.ready = dout.ready;
        end else begin
          s0.ready = dout.ready;
        end
        accept = own_valid & dout.ready;
        // A single-beat video packet must end the frame on its own sop beat.
        if (accept && own_sop) begin
          sop_video = (own_data[3:0] == 4'h0);
        end
        frame_end = accept & own_eop & sop_video;
        if (frame_end) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      in_video   <= 1'b0;
      grant      <= 2'b00;
      frame_done <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      in_video   <= frame_end ? 1'b0 : sop_video;
      frame_done <= frame_end;
      drop_pulse <= drop0 | drop1;
      if (arb_go) begin
        grant <= win ? 2'b10 : 2'b01;
      end else if (frame_end) begin
        grant <= 2'b00;
      end
      if (frame_end) begin
        last_owner <= owner;
      end
    end
  end

`ifdef VIP_ARB_FRAME_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count0 <= 16'h0000;
      frame_count1 <= 16'h0000;
    end else if (frame_end) begin
      if (owner) begin
        frame_count1 <= frame_count1 + 16'h0001;
      end else begin
        frame_count0 <= frame_count0 + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alt_vip_common_frame_arbiter.sv
// tb/tb_alt_vip_common_frame_arbiter.sv - scoreboard bench for the two-source VIP frame arbiter
module tb_alt_vip_common_frame_arbiter;

  localparam int DW = 24;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prio_mode = 1'b0;
  logic [1:0] grant;
  logic       frame_done;
  logic       drop_pulse;
`ifdef VIP_ARB_FRAME_COUNT_EN
  logic [15:0] frame_count0;
  logic [15:0] frame_count1;
`endif

  alt_vip_common_frame_arbiter_if #(.DW(DW)) s0_if ();
  alt_vip_common_frame_arbiter_if #(.DW(DW)) s1_if ();
  alt_vip_common_frame_arbiter_if #(.DW(DW)) dout_if ();

  alt_vip_common_frame_arbiter #(
    .BITS_PER_SYMBOL (8),
    .SYMBOLS_PER_BEAT(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s0          (s0_if),
    .s1          (s1_if),
    .dout        (dout_if),
    .prio_mode   (prio_mode),
    .grant       (grant),
    .frame_done  (frame_done),
    .drop_pulse  (drop_pulse)
`ifdef VIP_ARB_FRAME_COUNT_EN
    ,
    .frame_count0(frame_count0),
    .frame_count1(frame_count1)
`endif
  );

  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  beat_t q0[$];
  beat_t q1[$];
  bit    owner_log[$];
  bit    bp_en = 1'b0;
  bit    abort = 1'b0;
  bit    tb_in_video = 1'b0;
  bit    fd_exp = 1'b0;
  int    fd_cnt = 0;
  int    drop_cnt = 0;
  int    dv_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    dout_if.ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      tb_in_video = 1'b0;
      fd_exp      = 1'b0;
    end else begin
      check("frame_done", frame_done, fd_exp);
      if (fd_exp) check("grant_idle", grant, 2'b00);
      fd_exp = 1'b0;
      if (frame_done) fd_cnt++;
      if (drop_pulse) drop_cnt++;
      if (dout_if.valid) dv_cnt++;
      if (grant == 2'b01 && s1_if.valid) check("s1_ready_blocked", s1_if.ready, 1'b0);
      if (grant == 2'b10 && s0_if.valid) check("s0_ready_blocked", s0_if.ready, 1'b0);
      if (dout_if.valid && dout_if.ready) begin
        bit    ok;
        beat_t e;
        ok = (grant == 2'b01 && q0.size() != 0) || (grant == 2'b10 && q1.size() != 0);
        check("sb_avail", ok, 1'b1);
        if (ok) begin
          e = (grant == 2'b01) ? q0.pop_front() : q1.pop_front();
          check("beat", {dout_if.sop, dout_if.eop, dout_if.data}, e);
          if (e.sop) begin
            owner_log.push_back(grant == 2'b10);
            tb_in_video = (e.data[3:0] == 4'h0);
          end
          if (e.eop && tb_in_video) fd_exp = 1'b1;
        end
      end
    end
  end

  task automatic set_src(input int src, input logic v, input beat_t b);
    if (src == 0) begin
      s0_if.valid = v; s0_if.sop = b.sop; s0_if.eop = b.eop; s0_if.data = b.data;
    end else begin
      s1_if.valid = v; s1_if.sop = b.sop; s1_if.eop = b.eop; s1_if.data = b.data;
    end
  endtask

  task automatic drive_pkt(input int src, input logic [3:0] typ, input int nbeats,
                           input bit keep, input bit mis);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      int n = 0;
      b.data = DW'($urandom);
      if (i == 0 && !mis) b.data[3:0] = typ;
      b.sop = (i == 0) && !mis;
      b.eop = (i == nbeats - 1) && !mis;
      set_src(src, 1'b1, b);
      if (keep) begin
        if (src == 0) q0.push_back(b); else q1.push_back(b);
      end
      forever begin
        @(negedge clk);
        if (abort) begin
          set_src(src, 1'b0, '0);
          return;
        end
        if ((src == 0) ? s0_if.ready : s1_if.ready) break;
        n++;
        if (n > 2000) begin
          check("handshake_timeout", 64'(n), 64'd0);
          set_src(src, 1'b0, '0);
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    set_src(src, 1'b0, '0);
  endtask

  task automatic check_order(input string tag, input int n, input logic [7:0] exp);
    check({tag, "_len"}, 64'(owner_log.size()), 64'(n));
    for (int i = 0; i < n && i < owner_log.size(); i++) check(tag, owner_log[i], exp[i]);
    owner_log.delete();
  endtask

  task automatic settle(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_drain"}, 64'(q0.size() + q1.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    set_src(0, 1'b0, '0);
    set_src(1, 1'b0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_drop", drop_pulse, 1'b0);
    check("rst_dout_valid", dout_if.valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // T2: simultaneous sop after reset, round-robin alternates starting with s0
    fd_cnt = 0;
    fork
      begin drive_pkt(0, 4'h0, 5, 1, 0); drive_pkt(0, 4'h0, 4, 1, 0); end
      begin drive_pkt(1, 4'h0, 6, 1, 0); drive_pkt(1, 4'h0, 3, 1, 0); end
    join
    settle("t2");
    check_order("t2_order", 4, 8'b1010);
    check("t2_frames", 64'(fd_cnt), 64'd4);

    // T1: control packet stays attached to its video packet
    fd_cnt = 0;
    drive_pkt(0, 4'hF, 4, 1, 0);
    drive_pkt(0, 4'h0, 8, 1, 0);
    settle("t1");
    check_order("t1_order", 2, 8'b00);
    check("t1_frames", 64'(fd_cnt), 64'd1);

    // T3: fixed priority, s0 keeps winning
    prio_mode = 1'b1;
    fd_cnt = 0;
    fork
      begin repeat (3) drive_pkt(0, 4'h0, 4, 1, 0); end
      begin drive_pkt(1, 4'h0, 4, 1, 0); end
    join
    settle("t3");
    prio_mode = 1'b0;
    check_order("t3_order", 4, 8'b1000);
    check("t3_frames", 64'(fd_cnt), 64'd4);

    // T4: misaligned beats dropped while idle
    drop_cnt = 0;
    dv_cnt = 0;
    drive_pkt(1, 4'h3, 3, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("t4_drops", 64'(drop_cnt), 64'd3);
    check("t4_no_valid", 64'(dv_cnt), 64'd0);
    fd_cnt = 0;
    drive_pkt(1, 4'h0, 3, 1, 0);
    settle("t4");
    check_order("t4_order", 1, 8'b1);
    check("t4_frames", 64'(fd_cnt), 64'd1);

    // T5: back-pressure, then reset mid-packet
    bp_en = 1'b1;
    fd_cnt = 0;
    drive_pkt(0, 4'h0, 10, 1, 0);
    settle("t5_bp");
    check_order("t5_bp_order", 1, 8'b0);
    check("t5_bp_frames", 64'(fd_cnt), 64'd1);
    fork
      drive_pkt(0, 4'h0, 30, 1, 0);
      begin
        repeat (8) @(posedge clk);
        #3;
        abort = 1'b1;
        rst = 1'b1;
        #1;
        check("t5_rst_grant", grant, 2'b00);
        check("t5_rst_ready", s0_if.ready, 1'b0);
        check("t5_rst_valid", dout_if.valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        abort = 1'b0;
      end
    join
    bp_en = 1'b0;
    q0.delete();
    q1.delete();
    owner_log.delete();
    fd_cnt = 0;
    fork
      drive_pkt(0, 4'h0, 4, 1, 0);
      drive_pkt(1, 4'h0, 4, 1, 0);
    join
    settle("t5");
    check_order("t5_order", 2, 8'b10);
    check("t5_frames", 64'(fd_cnt), 64'd2);

`ifdef VIP_ARB_FRAME_COUNT_EN
    // T6: counter wrap
    force dut.frame_count0 = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_count0;
    drive_pkt(0, 4'h0, 3, 1, 0);
    settle("t6");
    owner_log.delete();
    check("t6_wrap", frame_count0, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
